// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - memcontrol encodings, captured-request type and legality helpers
package data_mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  localparam logic [2:0] MC_B  = 3'b000;
  localparam logic [2:0] MC_H  = 3'b001;
  localparam logic [2:0] MC_W  = 3'b010;
  localparam logic [2:0] MC_BU = 3'b100;
  localparam logic [2:0] MC_HU = 3'b101;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic              we;
    logic [MEM_DW-1:0] wdata;
    logic [2:0]        ctrl;
    logic              id;
  } mem_req_t;

  function automatic logic is_legal_load(input logic [2:0] ctrl);
    return (ctrl == MC_B) || (ctrl == MC_H) || (ctrl == MC_W) ||
           (ctrl == MC_BU) || (ctrl == MC_HU);
  endfunction

  function automatic logic is_legal_store(input logic [2:0] ctrl);
    return (ctrl == MC_B) || (ctrl == MC_H) || (ctrl == MC_W);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// rtl/data_mem_arbiter_rr.sv - two-way round-robin arbiter with bounded lock hold
module rr_arbiter2
  import data_mem_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);

  localparam int              CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LOCK);
  localparam logic [CW-1:0]   ONE     = CW'(1);

  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          w_hold;
  logic          w_id;

  // The last grantee keeps priority only while its lock budget is not exhausted.
  assign w_hold = i_lock[r_last] && (r_cnt < MAX_CNT);
  assign w_id   = o_gnt[1];

  always_comb begin
    o_gnt = 2'b00;
    if (rst_n) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (w_hold ? r_last : ~r_last) ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else if (|o_gnt) begin
      r_last <= w_id;
      if (!i_lock[w_id]) begin
        r_cnt <= '0;
      end else if (w_id != r_last) begin
        r_cnt <= ONE;
      end else if (r_cnt < MAX_CNT) begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - arbitrate / issue / respond pipeline sharing one data memory port
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = MEM_AW,
  parameter int DATA_WIDTH    = MEM_DW,
  parameter int MAX_LOCK      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_i,
  input  logic [1:0]               lock_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i  [0:1],
  input  logic [1:0]               we_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i [0:1],
  input  logic [2:0]               ctrl_i  [0:1],
  output logic [1:0]               gnt_o,
  output logic [1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     err_o,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata
);

  logic [1:0]            w_gnt;
  logic                  w_gnt_id;
  logic                  w_legal;
  mem_req_t              r_cap;
  logic                  r_cap_valid;
  logic [1:0]            r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  rr_arbiter2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (req_i),
    .i_lock (lock_i),
    .o_gnt  (w_gnt)
  );

  assign gnt_o    = w_gnt;
  assign w_gnt_id = w_gnt[1];

  // Payload holds through bubbles so mem_a keeps its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_valid <= 1'b0;
      r_cap.addr  <= '0;
      r_cap.we    <= 1'b0;
      r_cap.wdata <= '0;
      r_cap.ctrl  <= MC_W;
      r_cap.id    <= 1'b0;
    end else begin
      r_cap_valid <= |w_gnt;
      if (|w_gnt) begin
        r_cap.addr  <= addr_i[w_gnt_id];
        r_cap.we    <= we_i[w_gnt_id];
        r_cap.wdata <= wdata_i[w_gnt_id];
        r_cap.ctrl  <= ctrl_i[w_gnt_id];
        r_cap.id    <= w_gnt_id;
      end
    end
  end

  assign w_legal        = r_cap.we ? is_legal_store(r_cap.ctrl) : is_legal_load(r_cap.ctrl);
  assign mem_a          = r_cap.addr;
  assign mem_we         = r_cap_valid & r_cap.we & w_legal;
  assign mem_writedata  = r_cap.wdata;
  assign mem_memcontrol = r_cap.ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= r_cap_valid ? (r_cap.id ? 2'b10 : 2'b01) : 2'b00;
      r_rdata  <= (r_cap_valid && !r_cap.we && w_legal) ? mem_readdata : '0;
      r_err    <= r_cap_valid & ~w_legal;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i, lock_i, we_i;
  logic [31:0] addr_i  [0:1];
  logic [31:0] wdata_i [0:1];
  logic [2:0]  ctrl_i  [0:1];
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, mem_a, mem_writedata, mem_readdata;
  logic        err_o, mem_we;
  logic [2:0]  mem_memcontrol;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .ctrl_i(ctrl_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .mem_a(mem_a),
    .mem_we(mem_we), .mem_writedata(mem_writedata), .mem_memcontrol(mem_memcontrol),
    .mem_readdata(mem_readdata)
  );

  // Byte-addressed little-endian memory that sign/zero-extends by funct3.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
  assign a0 = mem_a[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    mem_readdata = {b3, b2, b1, b0};
    case (mem_memcontrol)
      3'b000:  mem_readdata = {{24{b0[7]}}, b0};
      3'b001:  mem_readdata = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_readdata = {24'b0, b0};
      3'b101:  mem_readdata = {16'b0, b1, b0};
      default: mem_readdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[a0] <= mem_writedata[7:0];
      if (mem_memcontrol != 3'b000) mem[a1] <= mem_writedata[15:8];
      if (mem_memcontrol == 3'b010) begin
        mem[a2] <= mem_writedata[23:16];
        mem[a3] <= mem_writedata[31:24];
      end
    end
  end

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid_o !== 2'b00) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid: got %b expected no response", rvalid_o);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_id", {30'b0, rvalid_o}, mon_e.id ? 32'd2 : 32'd1);
        check("rdata", rdata_o, mon_e.rdata);
        check("err", {31'b0, err_o}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic set_port(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
    we_i[p]    = we;
    addr_i[p]  = a;
    wdata_i[p] = d;
    ctrl_i[p]  = c;
  endtask

  // One arbitration cycle; exp_we < 0 skips the issue-stage write-enable check.
  task automatic cycle(input string name, input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] exp_gnt, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_we);
    exp_t e;
    req_i  = req;
    lock_i = lock;
    @(negedge clk);
    check(name, {30'b0, gnt_o}, {30'b0, exp_gnt});
    if (exp_we >= 0) check({name, "_mem_we"}, {31'b0, mem_we}, 32'(exp_we));
    if (push && exp_gnt != 2'b00) begin
      e.id    = exp_gnt[1];
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [1:0] lk_seq [0:5];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n  = 1'b0;
    req_i  = 2'b11;
    lock_i = 2'b00;
    set_port(0, 1'b1, 32'h0, 32'h0, MC_W);
    set_port(1, 1'b1, 32'h0, 32'h0, MC_W);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", {30'b0, gnt_o}, 32'd0);
    check("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check("reset_rvalid", {30'b0, rvalid_o}, 32'd0);
    check("reset_memcontrol", {29'b0, mem_memcontrol}, 32'd2);
    check("reset_rdata", rdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous requests from both ports alternate, port 0 first.
    set_port(0, 1'b1, 32'h40, 32'hA0A0A0A0, MC_W);
    set_port(1, 1'b1, 32'h44, 32'hB1B1B1B1, MC_W);
    for (int i = 0; i < 6; i++)
      cycle("rr_alt", 2'b11, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 32'h0, 1'b0, -1);
    cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, -1);
    cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);

    // Store then load of the same word in back-to-back grants.
    set_port(0, 1'b1, 32'h4, 32'hDEADBEEF, MC_W);
    cycle("sw_p0", 2'b01, 2'b00, 2'b01, 1'b1, 32'h0, 1'b0, 0);
    set_port(1, 1'b0, 32'h4, 32'h0, MC_W);
    cycle("lw_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, 1);

    // Sign and zero extension for bytes and halves.
    set_port(0, 1'b1, 32'h8, 32'h00000080, MC_B);
    cycle("sb_p0", 2'b01, 2'b00, 2'b01, 1'b1, 32'h0, 1'b0, 0);
    set_port(1, 1'b0, 32'h4, 32'h0, MC_H);
    cycle("lh_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'hFFFFBEEF, 1'b0, 1);
    set_port(1, 1'b0, 32'h4, 32'h0, MC_HU);
    cycle("lhu_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'h0000BEEF, 1'b0, 0);
    set_port(1, 1'b0, 32'h8, 32'h0, MC_B);
    cycle("lb_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'hFFFFFF80, 1'b0, 0);
    set_port(1, 1'b0, 32'h8, 32'h0, MC_BU);
    cycle("lbu_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'h00000080, 1'b0, 0);
    cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    check("idle_mem_a_hold", mem_a, 32'h8);
    check("idle_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;

    // Port 0 locked: four grants, then a forced hand-over to port 1.
    set_port(0, 1'b1, 32'h80, 32'hC0C0C0C0, MC_W);
    set_port(1, 1'b1, 32'h84, 32'hD0D0D0D0, MC_W);
    lk_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 6; i++)
      cycle("lock_seq", 2'b11, 2'b01, lk_seq[i], 1'b1, 32'h0, 1'b0, -1);
    cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, -1);

    // Illegal encodings never reach the memory and report err.
    set_port(0, 1'b1, 32'h60, 32'h00000055, 3'b011);
    cycle("sw_ill_011", 2'b01, 2'b00, 2'b01, 1'b1, 32'h0, 1'b1, -1);
    cycle("idle_ill", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    set_port(1, 1'b1, 32'h64, 32'h00000077, MC_BU);
    cycle("sw_ill_100", 2'b10, 2'b00, 2'b10, 1'b1, 32'h0, 1'b1, -1);
    cycle("idle_ill", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    set_port(0, 1'b0, 32'h4, 32'h0, 3'b011);
    cycle("lw_ill_011", 2'b01, 2'b00, 2'b01, 1'b1, 32'h0, 1'b1, -1);
    set_port(1, 1'b0, 32'h60, 32'h0, MC_W);
    cycle("lw_chk_60", 2'b10, 2'b00, 2'b10, 1'b1, 32'h0, 1'b0, 0);
    set_port(1, 1'b0, 32'h64, 32'h0, MC_W);
    cycle("lw_chk_64", 2'b10, 2'b00, 2'b10, 1'b1, 32'h0, 1'b0, 0);
    repeat (3) cycle("idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, -1);

    // Reset while a store sits in the capture register drops it.
    set_port(0, 1'b1, 32'h20, 32'h11223344, MC_W);
    cycle("sw_rst", 2'b01, 2'b00, 2'b01, 1'b0, 32'h0, 1'b0, 0);
    rst_n = 1'b0;
    req_i = 2'b11;
    #1;
    check("rst_drop_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_drop_gnt", {30'b0, gnt_o}, 32'd0);
    @(negedge clk);
    check("rst_drop_rvalid", {30'b0, rvalid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_port(0, 1'b0, 32'h20, 32'h0, MC_W);
    set_port(1, 1'b0, 32'h20, 32'h0, MC_W);
    cycle("post_rst_p0", 2'b11, 2'b00, 2'b01, 1'b1, 32'h0, 1'b0, 0);
    cycle("post_rst_p1", 2'b10, 2'b00, 2'b10, 1'b1, 32'h0, 1'b0, 0);
    repeat (4) cycle("drain", 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, -1);

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
